// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } vga_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Total positions along one axis (line length in pixels or frame height in lines).
    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational pattern source: picks external, colour-bar, checkerboard or solid colour.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int COLOR_W  = 1,
    parameter int CNT_W    = 10,
    parameter int CHK_LOG2 = 5
) (
    input  logic [CNT_W-1:0]     hcnt,
    input  logic [CNT_W-1:0]     vcnt,
    input  vga_mode_e            mode,
    input  logic [3*COLOR_W-1:0] solid,
    input  logic [3*COLOR_W-1:0] ext,
    output logic [3*COLOR_W-1:0] rgb
);

    logic [6:0] bar_ge;
    logic [2:0] bar_idx;
    logic       chk_bit;
    logic       unused_vcnt;

    // Bar index is the number of eighth-of-line thresholds already passed.
    generate
        for (genvar gi = 1; gi <= 7; gi++) begin : g_bar_th
            localparam logic [CNT_W-1:0] TH = CNT_W'((gi * H_ACTIVE) / 8);
            assign bar_ge[gi-1] = (hcnt >= TH);
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int k = 0; k < 7; k++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[k]};
        end
    end

    assign chk_bit     = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];
    assign unused_vcnt = ^vcnt;

    always_comb begin
        rgb = '0;
        case (mode)
            MODE_EXT:   rgb = ext;
            MODE_BARS:  rgb = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
            MODE_CHECK: rgb = {(3*COLOR_W){chk_bit}};
            MODE_SOLID: rgb = solid;
            default:    rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-strobed counters, frame-aligned mode latch,
// sync decode and a one-step registered output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   COLOR_W  = 1,
    parameter int   CNT_W    = 10,
    parameter int   CHK_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    input  logic [3*COLOR_W-1:0] ext_rgb,
    output logic                 req,
    output logic [CNT_W-1:0]     req_x,
    output logic [CNT_W-1:0]     req_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]     hcnt_reg, hcnt_next;
    logic [CNT_W-1:0]     vcnt_reg, vcnt_next;
    vga_mode_e            mode_reg, mode_eff;
    logic [3*COLOR_W-1:0] solid_reg, solid_eff;
    logic [3*COLOR_W-1:0] pat_rgb, rgb_next, rgb_reg;
    logic                 at_origin, active, hs_next, vs_next;
    logic                 hsync_reg, vsync_reg, de_reg;
    logic                 line_start_reg, frame_start_reg;

    assign at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);
    assign active    = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);

    // The origin pixel already uses the live selection that gets latched for the frame.
    assign mode_eff  = at_origin ? vga_mode_e'(mode) : mode_reg;
    assign solid_eff = at_origin ? solid_rgb : solid_reg;

    always_comb begin
        hcnt_next = hcnt_reg + CNT_W'(1);
        vcnt_next = vcnt_reg;
        if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + CNT_W'(1);
        end
    end

    assign hs_next  = ((hcnt_reg >= H_SYNC_ON) && (hcnt_reg < H_SYNC_OFF)) ? H_POL : ~H_POL;
    assign vs_next  = ((vcnt_reg >= V_SYNC_ON) && (vcnt_reg < V_SYNC_OFF)) ? V_POL : ~V_POL;
    assign rgb_next = active ? pat_rgb : '0;

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .hcnt  (hcnt_reg),
        .vcnt  (vcnt_reg),
        .mode  (mode_eff),
        .solid (solid_eff),
        .ext   (ext_rgb),
        .rgb   (pat_rgb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            mode_reg        <= MODE_EXT;
            solid_reg       <= '0;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            de_reg          <= 1'b0;
            rgb_reg         <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            // Pulses are rewritten every clk so they last exactly one clk.
            line_start_reg  <= pix_en && (hcnt_reg == '0);
            frame_start_reg <= pix_en && at_origin;
            if (pix_en) begin
                hcnt_reg  <= hcnt_next;
                vcnt_reg  <= vcnt_next;
                hsync_reg <= hs_next;
                vsync_reg <= vs_next;
                de_reg    <= active;
                rgb_reg   <= rgb_next;
                if (at_origin) begin
                    mode_reg  <= vga_mode_e'(mode);
                    solid_reg <= solid_rgb;
                end
            end
        end
    end

    assign req         = active;
    assign req_x       = hcnt_reg;
    assign req_y       = vcnt_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign r           = rgb_reg[3*COLOR_W-1:2*COLOR_W];
    assign g           = rgb_reg[2*COLOR_W-1:COLOR_W];
    assign b           = rgb_reg[COLOR_W-1:0];
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench: small-raster DUT checked every clk against a step-count model,
// plus a default 640x480 DUT checked for ext_rgb latency and line length.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int CW = 2, CL = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] solid_rgb = 6'd0;
    logic [5:0] ext_rgb = 6'd0;

    logic       req, hsync, vsync, de, line_start, frame_start;
    logic [9:0] req_x, req_y;
    logic [1:0] r, g, b;

    logic       req_d, hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
    logic [9:0] req_x_d, req_y_d;
    logic       r_d, g_d, b_d;
    logic [2:0] ext_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(CW), .CNT_W(10), .CHK_LOG2(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode),
        .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
        .req(req), .req_x(req_x), .req_y(req_y),
        .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
        .line_start(line_start), .frame_start(frame_start)
    );

    assign ext_d = req_x_d[2:0];

    vga_timing_gen dut_def (
        .clk(clk), .rst_n(rst_n), .pix_en(1'b1), .mode(2'd0),
        .solid_rgb(3'd0), .ext_rgb(ext_d),
        .req(req_d), .req_x(req_x_d), .req_y(req_y_d),
        .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .r(r_d), .g(g_d), .b(b_d),
        .line_start(line_start_d), .frame_start(frame_start_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (small DUT) ----------------
    int         n;
    logic [1:0] lmode;
    logic [5:0] lsolid;
    logic       e_hs, e_vs, e_de, e_ls, e_fs, stepped;
    logic [5:0] e_rgb;
    int         ex_x, ex_y;
    int         cnt_de, cnt_hsl, cnt_vsl;

    function automatic logic [5:0] pattern(input int x, input int y, input logic [1:0] m,
                                           input logic [5:0] s, input logic [5:0] e);
        int idx;
        logic [2:0] i3;
        if (!(x < HA && y < VA)) return 6'h00;
        case (m)
            2'd0: return e;
            2'd1: begin
                idx = 0;
                for (int k = 1; k < 8; k++) if ((k * HA) / 8 <= x) idx++;
                i3 = idx[2:0];
                return {{2{i3[2]}}, {2{i3[1]}}, {2{i3[0]}}};
            end
            2'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 6'h3F : 6'h00;
            default: return s;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0; lmode <= 2'd0; lsolid <= 6'd0;
            e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_rgb <= 6'd0;
            e_ls <= 1'b0; e_fs <= 1'b0; stepped <= 1'b0;
            ex_x <= -1; ex_y <= -1;
        end else begin
            stepped <= pix_en;
            e_ls <= 1'b0;
            e_fs <= 1'b0;
            if (pix_en) begin
                automatic int x = n % HT;
                automatic int y = n / HT;
                automatic logic origin = (x == 0) && (y == 0);
                automatic logic [1:0] m = origin ? mode : lmode;
                automatic logic [5:0] s = origin ? solid_rgb : lsolid;
                if (origin) begin
                    lmode  <= mode;
                    lsolid <= solid_rgb;
                end
                e_de  <= (x < HA) && (y < VA);
                e_hs  <= !(x >= HA + HF && x < HA + HF + HS);
                e_vs  <= !(y >= VA + VF && y < VA + VF + VS);
                e_rgb <= pattern(x, y, m, s, ext_rgb);
                e_ls  <= (x == 0);
                e_fs  <= origin;
                ex_x  <= x;
                ex_y  <= y;
                n     <= (n + 1) % (HT * VT);
            end
        end
    end

    always @(negedge clk) begin
        chk("req_x", 32'(req_x), 32'(n % HT));
        chk("req_y", 32'(req_y), 32'(n / HT));
        chk("req", 32'(req), 32'((n % HT) < HA && (n / HT) < VA));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("rgb", 32'({r, g, b}), 32'(e_rgb));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        if (stepped) begin
            cnt_de  += int'(de);
            cnt_hsl += int'(!hsync);
            cnt_vsl += int'(!vsync);
        end
    end

    always @(negedge clk) ext_rgb = 6'($urandom);

    // ---------------- default-size DUT checks ----------------
    logic [9:0] was_x2;
    logic       was_req2, was_valid2;
    int         gap2;
    bit         have2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            was_valid2 <= 1'b0;
        end else begin
            was_valid2 <= 1'b1;
            was_x2     <= req_x_d;
            was_req2   <= req_d;
        end
    end

    always @(negedge clk) begin
        if (was_valid2)
            chk("def_rgb", 32'({r_d, g_d, b_d}), was_req2 ? 32'(was_x2[2:0]) : 32'd0);
        if (!rst_n) begin
            have2 = 1'b0;
            gap2  = 0;
        end else begin
            gap2++;
            if (line_start_d) begin
                if (have2) chk("def_line_len", 32'(gap2), 32'd800);
                have2 = 1'b1;
                gap2  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_out(input int x, input int y, input int budget);
        int i;
        i = 0;
        while (!(stepped && ex_x == x && ex_y == y) && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (i >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_out: pixel (%0d,%0d) not output within %0d clks", x, y, budget);
        end
    endtask

    initial begin
        cnt_de = 0; cnt_hsl = 0; cnt_vsl = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        // Continuous strobe, colour bars from the very first pixel.
        mode = 2'd1;
        solid_rgb = 6'h15;
        rst_n = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        #1;
        chk("fs_clk1", 32'(frame_start), 32'd1);
        chk("ls_clk1", 32'(line_start), 32'd1);
        chk("de_clk1", 32'(de), 32'd1);
        repeat (HT * VT - 1) @(negedge clk);
        #1;
        chk("frame_de_count", 32'(cnt_de), 32'd32);
        chk("frame_hsync_low", 32'(cnt_hsl), 32'd14);
        chk("frame_vsync_low", 32'(cnt_vsl), 32'd14);

        wait_out(5, 1, 200);
        chk("bar5", 32'({r, g, b}), 32'h33);
        wait_out(7, 2, 200);
        chk("bar7", 32'({r, g, b}), 32'h3F);
        wait_out(0, 2, 200);
        chk("bar0", 32'({r, g, b}), 32'h00);

        // Mid-frame switch to solid: bars hold until the next frame.
        mode = 2'd3;
        solid_rgb = 6'h2A;
        wait_out(3, 3, 200);
        chk("bars_hold", 32'({r, g, b}), 32'h0F);
        wait_out(2, 1, 200);
        chk("solid_next_frame", 32'({r, g, b}), 32'h2A);
        wait_out(12, 1, 200);
        chk("solid_blank", 32'({r, g, b}), 32'h00);

        // Strobe every third clk with checkerboard.
        mode = 2'd2;
        for (int i = 0; i < 3 * HT * VT + 20; i++) begin
            @(negedge clk);
            pix_en = (i % 3 == 0);
        end

        // Random strobe, mode and solid colour.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) solid_rgb = 6'($urandom);
        end

        // Asynchronous reset mid-frame.
        pix_en = 1'b1;
        mode = 2'd1;
        wait_out(5, 2, 200);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_de", 32'(de), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd1);
        chk("arst_vsync", 32'(vsync), 32'd1);
        chk("arst_rgb", 32'({r, g, b}), 32'd0);
        chk("arst_req_x", 32'(req_x), 32'd0);
        chk("arst_req_y", 32'(req_y), 32'd0);
        chk("arst_ls", 32'(line_start), 32'd0);
        chk("arst_def_de", 32'(de_d), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("fs_after_rst", 32'(frame_start), 32'd1);
        chk("rgb_after_rst", 32'({r, g, b}), 32'h00);

        // Long random run so the default raster completes several lines.
        for (int i = 0; i < 1800; i++) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) solid_rgb = 6'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
